// File: rtl/coproc_seq_pkg.sv
// rtl/coproc_seq_pkg.sv - shared types and constants for the coprocessor UART sequencer
package coproc_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      ISSUE,
      WAIT,
      SEND
   } seq_state_t;

   // cmd[7] set means the host does not want the coprocessor result back
   localparam int         CMD_NORESP_BIT   = 7;
   localparam int         CTRL_W           = 6;
   localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

endpackage

// File: rtl/byte_serializer.sv
// rtl/byte_serializer.sv - parallel-load shift register streaming bytes MSB first
module byte_serializer #(
   parameter int WIDTH = 128,
   parameter int NB    = WIDTH / 8,
   parameter int CW    = $clog2(NB + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic [CW-1:0]    load_count,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             done
);

   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    sent;
   logic [CW-1:0]    total;
   logic             fire;

   // the byte on the wire is always the top of the shift register, so it
   // cannot change until the receiver takes it
   assign tx_data = shreg[WIDTH-1 -: 8];
   assign fire    = tx_valid && tx_ready;
   assign done    = fire && (sent == total - CW'(1));

   // load a new response, then shift one byte out per accepted handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg    <= '0;
         sent     <= '0;
         total    <= '0;
         tx_valid <= 1'b0;
      end else if (load) begin
         shreg    <= load_data;
         total    <= load_count;
         sent     <= '0;
         tx_valid <= 1'b1;
      end else if (fire) begin
         shreg <= {shreg[WIDTH-9:0], 8'h00};
         if (done) begin
            tx_valid <= 1'b0;
            sent     <= '0;
         end else begin
            sent <= sent + CW'(1);
         end
      end
   end

endmodule

// File: rtl/coproc_uart_sequencer.sv
// rtl/coproc_uart_sequencer.sv - frames UART bytes into coprocessor operations and returns results
module coproc_uart_sequencer
   import coproc_seq_pkg::*;
#(
   parameter int         WIDTH_DIN    = 128,
   parameter int         WIDTH_DOUT   = 128,
   parameter int         RESP_TIMEOUT = 64,
   parameter int         GAP_TIMEOUT  = 100000,
   parameter logic [7:0] ERR_BYTE     = DEFAULT_ERR_BYTE
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   output logic [WIDTH_DIN-1:0]  cp_din,
   output logic                  cp_din_valid,
   output logic [CTRL_W-1:0]     cp_control,
   input  logic [WIDTH_DOUT-1:0] cp_dout,
   input  logic                  cp_dout_valid,
   output logic                  busy,
   output logic                  err_timeout,
   output logic                  err_gap,
   output logic                  err_overrun
);

   localparam int NB_IN  = WIDTH_DIN / 8;
   localparam int NB_OUT = WIDTH_DOUT / 8;
   localparam int BCW    = $clog2(NB_IN + 1);
   localparam int GCW    = $clog2(GAP_TIMEOUT + 1);
   localparam int WCW    = $clog2(RESP_TIMEOUT + 1);
   localparam int SCW    = $clog2(NB_OUT + 1);

   localparam logic [BCW-1:0] BYTE_LAST = BCW'(NB_IN - 1);
   localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_TIMEOUT - 1);
   localparam logic [WCW-1:0] WAIT_LAST = WCW'(RESP_TIMEOUT - 1);

   seq_state_t      state;
   logic            noresp;
   logic [BCW-1:0]  byte_cnt;
   logic [GCW-1:0]  gap_cnt;
   logic [WCW-1:0]  wait_cnt;

   logic                  resp_hit;
   logic                  resp_to;
   logic                  ser_load;
   logic [WIDTH_DOUT-1:0] ser_data;
   logic [SCW-1:0]        ser_count;
   logic                  ser_done;

   assign busy = (state != IDLE);

   // the serializer is loaded on the same edge that enters SEND, so tx_valid
   // rises in the first SEND cycle; a timeout sends ERR_BYTE alone
   assign resp_hit  = (state == WAIT) && cp_dout_valid;
   assign resp_to   = (state == WAIT) && !cp_dout_valid && (wait_cnt == WAIT_LAST);
   assign ser_load  = resp_hit || resp_to;
   assign ser_data  = resp_hit ? cp_dout : {ERR_BYTE, {(WIDTH_DOUT-8){1'b0}}};
   assign ser_count = resp_hit ? SCW'(NB_OUT) : SCW'(1);

   byte_serializer #(
      .WIDTH (WIDTH_DOUT)
   ) u_ser (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (ser_load),
      .load_data  (ser_data),
      .load_count (ser_count),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .done       (ser_done)
   );

   // frame sequencing: collect cmd and payload, issue, await result, hand off to TX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         noresp       <= 1'b0;
         byte_cnt     <= '0;
         gap_cnt      <= '0;
         wait_cnt     <= '0;
         cp_din       <= '0;
         cp_din_valid <= 1'b0;
         cp_control   <= '0;
         err_timeout  <= 1'b0;
         err_gap      <= 1'b0;
         err_overrun  <= 1'b0;
      end else begin
         cp_din_valid <= 1'b0;
         err_timeout  <= 1'b0;
         err_gap      <= 1'b0;
         err_overrun  <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_valid) begin
                  cp_control <= rx_data[CTRL_W-1:0];
                  noresp     <= rx_data[CMD_NORESP_BIT];
                  byte_cnt   <= '0;
                  gap_cnt    <= '0;
                  state      <= LOAD;
               end
            end
            LOAD: begin
               if (rx_valid) begin
                  // shift in at the LSB end so the first payload byte lands on top
                  cp_din  <= {cp_din[WIDTH_DIN-9:0], rx_data};
                  gap_cnt <= '0;
                  if (byte_cnt == BYTE_LAST) begin
                     byte_cnt     <= '0;
                     cp_din_valid <= 1'b1;
                     state        <= ISSUE;
                  end else begin
                     byte_cnt <= byte_cnt + BCW'(1);
                  end
               end else if (gap_cnt == GAP_LAST) begin
                  err_gap  <= 1'b1;
                  gap_cnt  <= '0;
                  byte_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GCW'(1);
               end
            end
            ISSUE: begin
               wait_cnt <= '0;
               state    <= noresp ? IDLE : WAIT;
            end
            WAIT: begin
               if (ser_load) begin
                  err_timeout <= resp_to;
                  wait_cnt    <= '0;
                  state       <= SEND;
               end else begin
                  wait_cnt <= wait_cnt + WCW'(1);
               end
            end
            SEND: begin
               if (ser_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // bytes arriving while an operation is in flight cannot be buffered
         if (rx_valid && ((state == ISSUE) || (state == WAIT) || (state == SEND))) begin
            err_overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_coproc_uart_sequencer.sv
// tb/tb_coproc_uart_sequencer.sv - self-checking bench for coproc_uart_sequencer
module tb_coproc_uart_sequencer;

   logic         clk;
   logic         rst_n;
   logic [7:0]   rx_data;
   logic         rx_valid;
   logic [7:0]   tx_data;
   logic         tx_valid;
   logic         tx_ready;
   logic [127:0] cp_din;
   logic         cp_din_valid;
   logic [5:0]   cp_control;
   logic [127:0] cp_dout;
   logic         cp_dout_valid;
   logic         busy;
   logic         err_timeout;
   logic         err_gap;
   logic         err_overrun;

   coproc_uart_sequencer #(
      .WIDTH_DIN    (128),
      .WIDTH_DOUT   (128),
      .RESP_TIMEOUT (8),
      .GAP_TIMEOUT  (20),
      .ERR_BYTE     (8'hEE)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .cp_din        (cp_din),
      .cp_din_valid  (cp_din_valid),
      .cp_control    (cp_control),
      .cp_dout       (cp_dout),
      .cp_dout_valid (cp_dout_valid),
      .busy          (busy),
      .err_timeout   (err_timeout),
      .err_gap       (err_gap),
      .err_overrun   (err_overrun)
   );

   int total = 0;
   int bad   = 0;

   int cyc = 0;
   int last_rx_cyc = 0;
   int din_cnt = 0, din_cyc = 0, din_lag = 0;
   int to_cnt = 0, to_lag = 0, gap_n = 0, ovr_n = 0;
   logic [127:0] din_val;
   logic [5:0]   ctl_val;
   logic         prev_hold = 1'b0;
   logic [7:0]   hold_data;
   logic [7:0]   tx_got[$];
   logic [7:0]   exp_q[$];

   int   ready_mode = 0;
   int   stub_lat = 4;
   logic stub_mute = 1'b0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   // observe the DUT on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (rx_valid) last_rx_cyc = cyc;
      if (tx_valid && tx_ready) tx_got.push_back(tx_data);
      if (prev_hold && rst_n) check("tx_hold", 128'({tx_valid, tx_data}), 128'({1'b1, hold_data}));
      prev_hold = tx_valid && !tx_ready && rst_n;
      hold_data = tx_data;
      if (cp_din_valid) begin
         din_cnt++;
         din_val = cp_din;
         ctl_val = cp_control;
         din_lag = cyc - last_rx_cyc;
         din_cyc = cyc;
      end
      if (err_timeout) begin
         to_cnt++;
         to_lag = cyc - din_cyc;
      end
      if (err_gap) gap_n++;
      if (err_overrun) ovr_n++;
   end

   // TX sink readiness pattern
   initial begin
      tx_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            2:       tx_ready = 1'($urandom_range(0, 1));
            default: tx_ready = 1'b0;
         endcase
      end
   end

   // coprocessor stand-in: result = operand + 1 after stub_lat cycles
   initial begin : stub
      logic [127:0] cap;
      cp_dout = '0;
      cp_dout_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (cp_din_valid && !stub_mute) begin
            cap = cp_din;
            repeat (stub_lat) @(posedge clk);
            #1;
            cp_dout = cap + 128'd1;
            cp_dout_valid = 1'b1;
            @(posedge clk);
            #1;
            cp_dout_valid = 1'b0;
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   int din0;
   logic [7:0] cur_cmd;
   logic [127:0] cur_pl;

   task automatic start_frame(input logic [7:0] cmd, input logic [127:0] pl, input logic mute, input int gapmax);
      logic [127:0] r;
      exp_q.delete();
      tx_got.delete();
      if (!cmd[7]) begin
         if (mute) exp_q.push_back(8'hEE);
         else begin
            r = pl + 128'd1;
            for (int i = 0; i < 16; i++) exp_q.push_back(r[127-8*i -: 8]);
         end
      end
      cur_cmd   = cmd;
      cur_pl    = pl;
      din0      = din_cnt;
      stub_mute = mute;
      send_byte(cmd);
      for (int i = 0; i < 16; i++) begin
         idle_cycles($urandom_range(0, gapmax));
         send_byte(pl[127-8*i -: 8]);
      end
   endtask

   task automatic finish_frame();
      int k;
      k = 0;
      while (din_cnt == din0 && k < 20) begin
         @(negedge clk);
         #1;
         k++;
      end
      check("din_valid_cnt", 128'(din_cnt - din0), 128'(1));
      check("din_lag", 128'(din_lag), 128'(1));
      check("cp_din", din_val, cur_pl);
      check("cp_control", 128'(ctl_val), 128'(cur_cmd[5:0]));
      if (cur_cmd[7]) begin
         @(negedge clk);
         check("noresp_idle", 128'(busy), 128'(0));
         repeat (10) @(negedge clk);
         check("noresp_no_tx", 128'(tx_got.size()), 128'(0));
      end else begin
         k = 0;
         while (tx_got.size() < exp_q.size() && k < 500) begin
            @(negedge clk);
            #1;
            k++;
         end
         @(negedge clk);
         check("busy_after_tx", 128'(busy), 128'(0));
         check("txv_after_tx", 128'(tx_valid), 128'(0));
         repeat (3) @(negedge clk);
         check("tx_len", 128'(tx_got.size()), 128'(exp_q.size()));
         for (int i = 0; i < exp_q.size() && i < tx_got.size(); i++)
            check($sformatf("tx_byte%0d", i), 128'(tx_got[i]), 128'(exp_q[i]));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_frame(input logic [7:0] cmd, input logic [127:0] pl, input logic mute, input int gapmax);
      start_frame(cmd, pl, mute, gapmax);
      finish_frame();
   endtask

   initial begin : main
      logic [127:0] pl;
      int t0, g0, o0, k;
      rst_n = 1'b0;
      rx_data = '0;
      rx_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_tx_valid", 128'(tx_valid), 128'(0));
      check("rst_din_valid", 128'(cp_din_valid), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_errs", 128'({err_timeout, err_gap, err_overrun}), 128'(0));
      check("rst_cp_din", cp_din, 128'(0));
      check("rst_control", 128'(cp_control), 128'(0));
      check("rst_tx_data", 128'(tx_data), 128'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle_cycles(2);

      // round trip with -50
      ready_mode = 0;
      stub_lat = 4;
      pl = '1;
      pl[7:0] = 8'hCE;
      run_frame(8'h01, pl, 1'b0, 0);

      // backpressure, payload 50
      ready_mode = 1;
      run_frame(8'h01, 128'd50, 1'b0, 0);

      // response timeout
      ready_mode = 0;
      t0 = to_cnt;
      run_frame(8'h02, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 0);
      check("timeout_cnt", 128'(to_cnt - t0), 128'(1));
      check("timeout_lag", 128'(to_lag), 128'(9));

      // gap abort then a clean frame
      g0 = gap_n;
      din0 = din_cnt;
      send_byte(8'h01);
      for (int i = 0; i < 5; i++) send_byte(8'($urandom));
      idle_cycles(40);
      check("gap_err", 128'(gap_n - g0), 128'(1));
      check("gap_no_issue", 128'(din_cnt - din0), 128'(0));
      check("gap_idle", 128'(busy), 128'(0));
      run_frame(8'h01, 128'd5, 1'b0, 2);

      // no-response command
      run_frame(8'h83, 128'd101, 1'b0, 0);

      // overrun during SEND while TX is stalled
      ready_mode = 3;
      o0 = ovr_n;
      start_frame(8'h01, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);
      k = 0;
      while (!tx_valid && k < 50) begin
         @(negedge clk);
         #1;
         k++;
      end
      @(posedge clk);
      #1;
      send_byte(8'h5A);
      repeat (2) @(negedge clk);
      check("overrun_cnt", 128'(ovr_n - o0), 128'(1));
      check("overrun_no_tx", 128'(tx_got.size()), 128'(0));
      ready_mode = 0;
      finish_frame();

      // reset in the middle of SEND
      ready_mode = 0;
      start_frame(8'h01, {$urandom, $urandom, $urandom, $urandom}, 1'b0, 0);
      k = 0;
      while (tx_got.size() < 3 && k < 100) begin
         @(negedge clk);
         #1;
         k++;
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_txv", 128'(tx_valid), 128'(0));
      check("rst_mid_busy", 128'(busy), 128'(0));
      idle_cycles(3);
      rst_n = 1'b1;
      idle_cycles(8);
      run_frame(8'h01, 128'd50, 1'b0, 0);

      // randomized frames against the model
      for (int n = 0; n < 12; n++) begin
         ready_mode = $urandom_range(0, 2);
         stub_lat   = $urandom_range(1, 6);
         run_frame({($urandom_range(0, 3) == 0), 1'($urandom), 6'($urandom)},
                   {$urandom, $urandom, $urandom, $urandom},
                   ($urandom_range(0, 4) == 0), 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
